// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: uniform stall/flush control for every
// stage register in the datapath, plus the default datapath width.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 64;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with a load enable
// and a clear (flush) that takes priority over loading.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = PIPE_DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter bit               ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             d_valid_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                data_d = RESET_VAL;
            end
        end else if (load_en_i) begin
            data_d  = d_i;
            valid_d = d_valid_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o       = data_q;
    assign q_valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register chain with stall (hold), flush (bubble
// insertion) and a registered occupancy count of valid stages.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = PIPE_DATA_W,
    parameter int unsigned      DEPTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter bit               ZERO_ON_FLUSH = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_stage_reg: DEPTH must be >= 1");
    end

    pipe_ctrl_t       ctrl;
    logic             load_en;
    logic [WIDTH-1:0] data_w [DEPTH];
    logic [DEPTH-1:0] valid_w;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign ctrl    = '{stall: stall, flush: flush};
    assign load_en = !ctrl.flush && !ctrl.stall;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] cell_d;
        logic             cell_v;

        if (i == 0) begin : g_head
            assign cell_d = d;
            assign cell_v = d_valid;
        end else begin : g_link
            assign cell_d = data_w[i-1];
            assign cell_v = valid_w[i-1];
        end

        pipe_stage_cell #(
            .WIDTH        (WIDTH),
            .RESET_VAL    (RESET_VAL),
            .ZERO_ON_FLUSH(ZERO_ON_FLUSH)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .load_en_i(load_en),
            .clear_i  (ctrl.flush),
            .d_i      (cell_d),
            .d_valid_i(cell_v),
            .q_o      (data_w[i]),
            .q_valid_o(valid_w[i])
        );
    end

    // Entry and exit are counted in modular OCC_W arithmetic; the result is
    // always in range even if the intermediate sum wraps.
    always_comb begin
        occ_d = occ_q;
        if (ctrl.flush) begin
            occ_d = '0;
        end else if (!ctrl.stall) begin
            occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_w[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        occ_q == OCC_W'($countones(valid_w)));

    assign q         = data_w[DEPTH-1];
    assign q_valid   = valid_w[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: four pipe_stage_reg configurations share one stimulus
// stream and are compared every cycle against a history-based model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] d = '0;
    logic        d_valid = 1'b0;

    logic [63:0] q0, q1, q2;
    logic [7:0]  q3;
    logic        qv0, qv1, qv2, qv3;
    logic [1:0]  oc0, oc1;
    logic [2:0]  oc2;
    logic [0:0]  oc3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // u0: DEPTH 3 zeroing flush, u1: DEPTH 3 valid-only flush,
    // u2: DEPTH 4, u3: DEPTH 1 WIDTH 8
    pipe_stage_reg #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0), .ZERO_ON_FLUSH(1'b1)) u0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q0), .q_valid(qv0), .occupancy(oc0));
    pipe_stage_reg #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0), .ZERO_ON_FLUSH(1'b0)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .occupancy(oc1));
    pipe_stage_reg #(.WIDTH(64), .DEPTH(4), .RESET_VAL(64'h0), .ZERO_ON_FLUSH(1'b1)) u2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q2), .q_valid(qv2), .occupancy(oc2));
    pipe_stage_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .ZERO_ON_FLUSH(1'b1)) u3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d[7:0]), .d_valid(d_valid),
        .q(q3), .q_valid(qv3), .occupancy(oc3));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: per configuration, a history of advanced inputs (index 0 newest).
    // q is the entry DEPTH advances old; occupancy is a popcount of the window.
    int          dep [4] = '{3, 3, 4, 1};
    bit          zof [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] hd  [4][4] = '{default: '0};
    logic        hv  [4][4] = '{default: 1'b0};

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                for (int j = 0; j < 4; j++) begin
                    hd[k][j] = '0;
                    hv[k][j] = 1'b0;
                end
            end else if (flush) begin
                for (int j = 0; j < 4; j++) begin
                    hv[k][j] = 1'b0;
                    if (zof[k]) hd[k][j] = '0;
                end
            end else if (!stall) begin
                for (int j = 3; j > 0; j--) begin
                    hd[k][j] = hd[k][j-1];
                    hv[k][j] = hv[k][j-1];
                end
                hd[k][0] = (k == 3) ? {56'h0, d[7:0]} : d;
                hv[k][0] = d_valid;
            end
        end
    end

    logic [63:0] dq  [4];
    logic        dqv [4];
    logic [63:0] doc [4];
    assign dq[0] = q0;  assign dq[1] = q1;  assign dq[2] = q2;  assign dq[3] = {56'h0, q3};
    assign dqv[0] = qv0; assign dqv[1] = qv1; assign dqv[2] = qv2; assign dqv[3] = qv3;
    assign doc[0] = 64'(oc0); assign doc[1] = 64'(oc1);
    assign doc[2] = 64'(oc2); assign doc[3] = 64'(oc3);

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int cnt;
            cnt = 0;
            for (int j = 0; j < dep[k]; j++) cnt += int'(hv[k][j]);
            chk($sformatf("model_q[%0d]", k), dq[k], hd[k][dep[k]-1]);
            chk($sformatf("model_qv[%0d]", k), 64'(dqv[k]), 64'(hv[k][dep[k]-1]));
            chk($sformatf("model_occ[%0d]", k), doc[k], 64'(cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    bit pat [10] = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    int maxocc;

    initial begin
        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_q", q0, 64'h0);
        chk("rst_qv", 64'(qv0), 64'h0);
        chk("rst_occ", 64'(oc0), 64'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Single valid word through DEPTH=3
        d = 64'h11111111; d_valid = 1'b1;
        step();
        chk("pt_occ1", 64'(oc0), 64'd1);
        chk("pt_qv1", 64'(qv0), 64'd0);
        chk("pt_d1_q", 64'(q3), 64'h11);
        d = '0; d_valid = 1'b0;
        step();
        chk("pt_occ2", 64'(oc0), 64'd1);
        step();
        chk("pt_q3", q0, 64'h11111111);
        chk("pt_qv3", 64'(qv0), 64'd1);
        chk("pt_occ3", 64'(oc0), 64'd1);
        step();
        chk("pt_occ4", 64'(oc0), 64'd0);
        chk("pt_qv4", 64'(qv0), 64'd0);

        // Stall holds everything while d keeps changing
        d = 64'hAAAAAAAA; d_valid = 1'b1; step();
        d = 64'h55555555; step();
        chk("st_occ_pre", 64'(oc0), 64'd2);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'h1234_5678_0000_0000 + 64'(i);
            step();
            chk("st_occ", 64'(oc0), 64'd2);
            chk("st_q", q0, 64'h0);
            chk("st_qv", 64'(qv0), 64'd0);
        end
        stall = 1'b0; d = '0; d_valid = 1'b0;
        step();
        chk("st_exit_q", q0, 64'hAAAAAAAA);
        chk("st_exit_qv", 64'(qv0), 64'd1);

        // Fill, then flush together with stall
        d_valid = 1'b1;
        d = 64'hC1; step();
        d = 64'hC2; step();
        d = 64'hC3; step();
        chk("fl_full_occ", 64'(oc0), 64'd3);
        chk("fl_full_q", q0, 64'hC1);
        flush = 1'b1; stall = 1'b1; d = '1;
        step();
        chk("fl_qv", 64'(qv0), 64'd0);
        chk("fl_occ", 64'(oc0), 64'd0);
        chk("fl_q_zero", q0, 64'h0);
        chk("fl_q_hold", q1, 64'hC1);
        chk("fl_qv_hold", 64'(qv1), 64'd0);
        flush = 1'b0; stall = 1'b0; d = '0; d_valid = 1'b0;

        // Bubble pattern through DEPTH=4
        maxocc = 0;
        for (int i = 0; i < 10; i++) begin
            d = 64'hD0 + 64'(i); d_valid = pat[i];
            step();
            if (int'(oc2) > maxocc) maxocc = int'(oc2);
            if (i >= 3) chk("bub_qv", 64'(qv2), 64'(pat[i-3]));
        end
        chk("bub_maxocc", 64'(maxocc), 64'd3);

        // DEPTH=1 as a plain enabled register
        d = 64'h10; d_valid = 1'b1; step();
        chk("d1_q", 64'(q3), 64'h10);
        chk("d1_qv", 64'(qv3), 64'd1);
        stall = 1'b1; d = 64'hFF; step();
        chk("d1_stall_q", 64'(q3), 64'h10);
        stall = 1'b0; flush = 1'b1; step();
        chk("d1_fl_qv", 64'(qv3), 64'd0);
        chk("d1_fl_q", 64'(q3), 64'h00);
        flush = 1'b0;

        // Reset between edges discards in-flight data
        d = 64'hE1; d_valid = 1'b1; step();
        d = 64'hE2; step();
        chk("mr_occ_pre", 64'(oc0), 64'd2);
        d = '0; d_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mr_q", q0, 64'h0);
        chk("mr_qv", 64'(qv0), 64'd0);
        chk("mr_occ", 64'(oc0), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_no_stale", 64'(qv0), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
